// File: rtl/axil_master_pkg.sv
// ============================================================================
// Module  : axil_master_pkg
// Purpose : Shared types for the AXI4-lite register master (FSM states,
//           AXI response codes, response record).
// Rev     : 1.0 - initial release
// ============================================================================
`default_nettype none

package axil_master_pkg;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      WR_AW_W = 3'd1,
      WR_B    = 3'd2,
      RD_AR   = 3'd3,
      RD_R    = 3'd4
   } state_t;

   localparam logic [1:0] OKAY   = 2'b00;
   localparam logic [1:0] SLVERR = 2'b10;
   localparam logic [1:0] DECERR = 2'b11;

   typedef struct packed {
      logic        write;
      logic [31:0] rdata;
      logic [1:0]  resp;
      logic        timeout;
   } rsp_t;

endpackage

`default_nettype wire

// File: rtl/axil_reg_master.sv
// ============================================================================
// Module  : axil_reg_master
// Purpose : Command-stream to single-beat AXI4-lite read/write initiator,
//           one outstanding transaction. Optional watchdog: AXIL_MASTER_TIMEOUT_EN.
// Rev     : 1.0 - initial release
// ============================================================================
`default_nettype none

module axil_reg_master
   import axil_master_pkg::*;
#(
   parameter int ADDRESS_WIDTH  = 11,
   parameter int TIMEOUT_CYCLES = 256
) (
   input  logic                     clk_i,
   input  logic                     reset_i,
   input  logic                     cmd_valid_i,
   output logic                     cmd_ready_o,
   input  logic                     cmd_write_i,
   input  logic [ADDRESS_WIDTH-1:0] cmd_addr_i,
   input  logic [31:0]              cmd_wdata_i,
   output logic                     rsp_valid_o,
   input  logic                     rsp_ready_i,
   output logic                     rsp_write_o,
   output logic [31:0]              rsp_rdata_o,
   output logic [1:0]               rsp_resp_o,
   output logic                     rsp_timeout_o,
   output logic [ADDRESS_WIDTH-1:0] m_axi_awaddr,
   output logic                     m_axi_awvalid,
   input  logic                     m_axi_awready,
   output logic [31:0]              m_axi_wdata,
   output logic [3:0]               m_axi_wstrb,
   output logic                     m_axi_wvalid,
   input  logic                     m_axi_wready,
   input  logic [1:0]               m_axi_bresp,
   input  logic                     m_axi_bvalid,
   output logic                     m_axi_bready,
   output logic [ADDRESS_WIDTH-1:0] m_axi_araddr,
   output logic                     m_axi_arvalid,
   input  logic                     m_axi_arready,
   input  logic [31:0]              m_axi_rdata,
   input  logic [1:0]               m_axi_rresp,
   input  logic                     m_axi_rvalid,
   output logic                     m_axi_rready
);

   localparam logic [ADDRESS_WIDTH-1:0] ADDR_MASK = {{(ADDRESS_WIDTH-2){1'b1}}, 2'b00};

   generate
      if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
         $error("TIMEOUT_CYCLES must be at least 1");
      end
   endgenerate

   state_t                   state_q, state_d;
   logic [ADDRESS_WIDTH-1:0] addr_q, addr_d;
   logic [31:0]              wdata_q, wdata_d;
   logic                     awvalid_q, awvalid_d;
   logic                     wvalid_q, wvalid_d;
   logic                     arvalid_q, arvalid_d;
   logic                     rsp_valid_q, rsp_valid_d;
   rsp_t                     rsp_q, rsp_d;

`ifdef AXIL_MASTER_TIMEOUT_EN
   localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [WD_W-1:0] wd_q, wd_d;
   logic            wd_expired;
`endif

   always_comb begin
      state_d       = state_q;
      addr_d        = addr_q;
      wdata_d       = wdata_q;
      awvalid_d     = awvalid_q;
      wvalid_d      = wvalid_q;
      arvalid_d     = arvalid_q;
      rsp_valid_d   = rsp_valid_q;
      rsp_d         = rsp_q;
      m_axi_bready  = 1'b0;
      m_axi_rready  = 1'b0;
      cmd_ready_o   = (state_q == IDLE) && !rsp_valid_q;

      if (rsp_valid_q && rsp_ready_i) begin
         rsp_valid_d = 1'b0;
      end

      case (state_q)
         IDLE: begin
`ifdef AXIL_MASTER_TIMEOUT_EN
            // Sink late beats of a transaction the watchdog already closed.
            m_axi_bready = 1'b1;
            m_axi_rready = 1'b1;
`endif
            if (cmd_valid_i && cmd_ready_o) begin
               addr_d = cmd_addr_i & ADDR_MASK;
               if (cmd_write_i) begin
                  wdata_d   = cmd_wdata_i;
                  awvalid_d = 1'b1;
                  wvalid_d  = 1'b1;
                  state_d   = WR_AW_W;
               end else begin
                  arvalid_d = 1'b1;
                  state_d   = RD_AR;
               end
            end
         end
         WR_AW_W: begin
            if (m_axi_awready) awvalid_d = 1'b0;
            if (m_axi_wready)  wvalid_d  = 1'b0;
            if (!awvalid_d && !wvalid_d) state_d = WR_B;
         end
         WR_B: begin
            m_axi_bready = 1'b1;
            if (m_axi_bvalid) begin
               rsp_d       = '{write: 1'b1, rdata: 32'h0, resp: m_axi_bresp, timeout: 1'b0};
               rsp_valid_d = 1'b1;
               state_d     = IDLE;
            end
         end
         RD_AR: begin
            if (m_axi_arready) begin
               arvalid_d = 1'b0;
               state_d   = RD_R;
            end
         end
         RD_R: begin
            m_axi_rready = 1'b1;
            if (m_axi_rvalid) begin
               rsp_d       = '{write: 1'b0, rdata: m_axi_rdata, resp: m_axi_rresp, timeout: 1'b0};
               rsp_valid_d = 1'b1;
               state_d     = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

`ifdef AXIL_MASTER_TIMEOUT_EN
      // A genuine B/R beat in the expiry cycle wins over the watchdog.
      wd_expired = (state_q != IDLE) && (wd_q == WD_W'(TIMEOUT_CYCLES - 1));
      if (wd_expired && (state_d == state_q)) begin
         awvalid_d   = 1'b0;
         wvalid_d    = 1'b0;
         arvalid_d   = 1'b0;
         rsp_d       = '{write: (state_q == WR_AW_W) || (state_q == WR_B),
                         rdata: 32'h0, resp: SLVERR, timeout: 1'b1};
         rsp_valid_d = 1'b1;
         state_d     = IDLE;
      end
      wd_d = ((state_d != state_q) || (state_q == IDLE)) ? '0 : wd_q + 1'b1;
`endif
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         state_q     <= IDLE;
         addr_q      <= '0;
         wdata_q     <= '0;
         awvalid_q   <= 1'b0;
         wvalid_q    <= 1'b0;
         arvalid_q   <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_q       <= '0;
`ifdef AXIL_MASTER_TIMEOUT_EN
         wd_q        <= '0;
`endif
      end else begin
         state_q     <= state_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         awvalid_q   <= awvalid_d;
         wvalid_q    <= wvalid_d;
         arvalid_q   <= arvalid_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_q       <= rsp_d;
`ifdef AXIL_MASTER_TIMEOUT_EN
         wd_q        <= wd_d;
`endif
      end
   end

   assign m_axi_awaddr  = addr_q;
   assign m_axi_araddr  = addr_q;
   assign m_axi_awvalid = awvalid_q;
   assign m_axi_wvalid  = wvalid_q;
   assign m_axi_arvalid = arvalid_q;
   assign m_axi_wdata   = wdata_q;
   assign m_axi_wstrb   = 4'hF;

   assign rsp_valid_o   = rsp_valid_q;
   assign rsp_write_o   = rsp_q.write;
   assign rsp_rdata_o   = rsp_q.rdata;
   assign rsp_resp_o    = rsp_q.resp;
   assign rsp_timeout_o = rsp_q.timeout;

endmodule

`default_nettype wire
